// File: rtl/core_pkg.sv
// Shared RV32 core constants: forward-select codes, datapath width default
// and the ALU operation encoding width.
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int ALU_OP_W = 4;

  localparam logic [2:0] FWD_RF   = 3'b000;
  localparam logic [2:0] FWD_EX   = 3'b001;
  localparam logic [2:0] FWD_MEM  = 3'b010;
  localparam logic [2:0] FWD_LOAD = 3'b011;
  localparam logic [2:0] FWD_WB   = 3'b100;

endpackage

// File: rtl/operand_fwd_mux.sv
// 5:1 operand forwarding mux; undefined select codes fall back to register-file
// data and raise illegal.
module operand_fwd_mux
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      sel,
  input  logic [XLEN-1:0] rf_data,
  input  logic [XLEN-1:0] ex_data,
  input  logic [XLEN-1:0] mem_data,
  input  logic [XLEN-1:0] load_data,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] op,
  output logic            illegal
);

  // operand select by forward code
  always_comb begin
    op      = rf_data;
    illegal = 1'b0;
    case (sel)
      FWD_RF:   op = rf_data;
      FWD_EX:   op = ex_data;
      FWD_MEM:  op = mem_data;
      FWD_LOAD: op = load_data;
      FWD_WB:   op = wb_data;
      default: begin
        op      = rf_data;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID operand forwarding plus the ID/EX pipeline register, with bubble insertion
// on stall/flush, a sticky illegal-forward flag and a saturating bubble counter.
module id_ex_operand_stage
  import core_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                id_valid,
  input  logic                pc_en,
  input  logic                PCSel,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  input  logic [XLEN-1:0]     imm_ID,
  input  logic [XLEN-1:0]     pc_ID,
  input  logic [4:0]          rd_ID,
  input  logic                RegWrite_ID,
  input  logic                LoadSel_ID,
  input  logic                MemWrite_ID,
  input  logic [ALU_OP_W-1:0] alu_op_ID,
  input  logic [2:0]          ForwardA,
  input  logic [2:0]          ForwardB,
  input  logic [XLEN-1:0]     fwd_ex_data,
  input  logic [XLEN-1:0]     fwd_mem_data,
  input  logic [XLEN-1:0]     fwd_load_data,
  input  logic [XLEN-1:0]     fwd_wb_data,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_op_a,
  output logic [XLEN-1:0]     ex_op_b,
  output logic [XLEN-1:0]     ex_imm,
  output logic [XLEN-1:0]     ex_pc,
  output logic [4:0]          ex_rd,
  output logic                RegWrite_ex,
  output logic                LoadSel_ex,
  output logic                MemWrite_ex,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                fwd_illegal,
  output logic [CNT_W-1:0]    bubble_count
);

  logic [XLEN-1:0] mux_a_s, mux_b_s;
  logic            ill_a_s, ill_b_s;
  logic            bubble_s;

  logic                valid_q, valid_d;
  logic [XLEN-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [XLEN-1:0]     imm_q, imm_d, pc_q, pc_d;
  logic [4:0]          rd_q, rd_d;
  logic                rw_q, rw_d, ls_q, ls_d, mw_q, mw_d;
  logic [ALU_OP_W-1:0] alu_q, alu_d;
  logic                ill_q, ill_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd_a (
    .sel(ForwardA), .rf_data(rs1_data), .ex_data(fwd_ex_data),
    .mem_data(fwd_mem_data), .load_data(fwd_load_data), .wb_data(fwd_wb_data),
    .op(mux_a_s), .illegal(ill_a_s)
  );

  operand_fwd_mux #(.XLEN(XLEN)) u_fwd_b (
    .sel(ForwardB), .rf_data(rs2_data), .ex_data(fwd_ex_data),
    .mem_data(fwd_mem_data), .load_data(fwd_load_data), .wb_data(fwd_wb_data),
    .op(mux_b_s), .illegal(ill_b_s)
  );

  // flush and stall collapse into a single bubble
  assign bubble_s = PCSel | ~pc_en;

  // next-state for the ID/EX bundle, sticky flag and bubble counter
  always_comb begin
    op_a_d  = mux_a_s;
    op_b_d  = mux_b_s;
    imm_d   = imm_ID;
    pc_d    = pc_ID;
    alu_d   = alu_op_ID;
    valid_d = 1'b0;
    rd_d    = 5'd0;
    rw_d    = 1'b0;
    ls_d    = 1'b0;
    mw_d    = 1'b0;
    if (!bubble_s && id_valid) begin
      valid_d = 1'b1;
      rd_d    = rd_ID;
      rw_d    = RegWrite_ID;
      ls_d    = LoadSel_ID;
      mw_d    = MemWrite_ID;
    end else begin
      valid_d = 1'b0;
      rd_d    = 5'd0;
    end

    ill_d = ill_q | ((ill_a_s | ill_b_s) & id_valid & ~bubble_s);

    if (bubble_s && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      rd_q    <= 5'd0;
      rw_q    <= 1'b0;
      ls_q    <= 1'b0;
      mw_q    <= 1'b0;
      alu_q   <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      ls_q    <= ls_d;
      mw_q    <= mw_d;
      alu_q   <= alu_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_op_a      = op_a_q;
  assign ex_op_b      = op_b_q;
  assign ex_imm       = imm_q;
  assign ex_pc        = pc_q;
  assign ex_rd        = rd_q;
  assign RegWrite_ex  = rw_q;
  assign LoadSel_ex   = ls_q;
  assign MemWrite_ex  = mw_q;
  assign ex_alu_op    = alu_q;
  assign fwd_illegal  = ill_q;
  assign bubble_count = cnt_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: driver queues hand-computed
// expectations, a monitor pops and compares one per EX update.
module tb_id_ex_operand_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        id_valid = 1'b0, pc_en = 1'b1, PCSel = 1'b0;
  logic [31:0] rs1_data = 32'h11, rs2_data = 32'h77;
  logic [31:0] imm_ID = 32'h0, pc_ID = 32'h0;
  logic [4:0]  rd_ID = 5'd0;
  logic        RegWrite_ID = 1'b0, LoadSel_ID = 1'b0, MemWrite_ID = 1'b0;
  logic [3:0]  alu_op_ID = 4'd0;
  logic [2:0]  ForwardA = 3'd0, ForwardB = 3'd0;
  logic [31:0] fwd_ex_data = 32'h22, fwd_mem_data = 32'h33;
  logic [31:0] fwd_load_data = 32'h44, fwd_wb_data = 32'h55;

  logic        ex_valid, RegWrite_ex, LoadSel_ex, MemWrite_ex, fwd_illegal;
  logic [31:0] ex_op_a, ex_op_b, ex_imm, ex_pc;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;
  logic [3:0]  bubble_count;

  id_ex_operand_stage #(.XLEN(32), .CNT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .id_valid(id_valid), .pc_en(pc_en),
    .PCSel(PCSel), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_ID(imm_ID),
    .pc_ID(pc_ID), .rd_ID(rd_ID), .RegWrite_ID(RegWrite_ID),
    .LoadSel_ID(LoadSel_ID), .MemWrite_ID(MemWrite_ID), .alu_op_ID(alu_op_ID),
    .ForwardA(ForwardA), .ForwardB(ForwardB), .fwd_ex_data(fwd_ex_data),
    .fwd_mem_data(fwd_mem_data), .fwd_load_data(fwd_load_data),
    .fwd_wb_data(fwd_wb_data), .ex_valid(ex_valid), .ex_op_a(ex_op_a),
    .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .RegWrite_ex(RegWrite_ex), .LoadSel_ex(LoadSel_ex),
    .MemWrite_ex(MemWrite_ex), .ex_alu_op(ex_alu_op),
    .fwd_illegal(fwd_illegal), .bubble_count(bubble_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [31:0] a, b, imm, pc;
    logic [4:0]  rd;
    logic [2:0]  ctl;
    logic [3:0]  alu;
    logic        ill;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_step = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // monitor: the EX register updates every posedge, compare just after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ex_valid", 32'(ex_valid), 32'(e.v));
        chk("ex_op_a", ex_op_a, e.a);
        chk("ex_op_b", ex_op_b, e.b);
        chk("ex_imm", ex_imm, e.imm);
        chk("ex_pc", ex_pc, e.pc);
        chk("ex_rd", 32'(ex_rd), 32'(e.rd));
        chk("RegWrite_ex", 32'(RegWrite_ex), 32'(e.ctl[2]));
        chk("LoadSel_ex", 32'(LoadSel_ex), 32'(e.ctl[1]));
        chk("MemWrite_ex", 32'(MemWrite_ex), 32'(e.ctl[0]));
        chk("ex_alu_op", 32'(ex_alu_op), 32'(e.alu));
        chk("fwd_illegal", 32'(fwd_illegal), 32'(e.ill));
        chk("bubble_count", 32'(bubble_count), 32'(e.cnt));
      end
    end
  end

  // ctl / e_ctl are {RegWrite, LoadSel, MemWrite}
  task automatic step(input logic v, input logic pe, input logic ps,
                      input logic [2:0] fa, input logic [2:0] fb,
                      input logic [4:0] rd, input logic [2:0] ctl,
                      input logic e_v, input logic [31:0] e_a, input logic [31:0] e_b,
                      input logic [4:0] e_rd, input logic [2:0] e_ctl,
                      input logic e_ill, input logic [3:0] e_cnt);
    exp_t e;
    @(negedge clock);
    n_step++;
    id_valid = v; pc_en = pe; PCSel = ps;
    ForwardA = fa; ForwardB = fb; rd_ID = rd;
    {RegWrite_ID, LoadSel_ID, MemWrite_ID} = ctl;
    imm_ID = 32'h100 + 32'(n_step);
    pc_ID = 32'h1000 + 32'(n_step * 4);
    alu_op_ID = 4'(n_step);
    e.v = e_v; e.a = e_a; e.b = e_b; e.rd = e_rd; e.ctl = e_ctl;
    e.ill = e_ill; e.cnt = e_cnt;
    e.imm = imm_ID; e.pc = pc_ID; e.alu = alu_op_ID;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".ex_valid"}, 32'(ex_valid), 32'd0);
    chk({tag, ".ex_op_a"}, ex_op_a, 32'd0);
    chk({tag, ".ex_op_b"}, ex_op_b, 32'd0);
    chk({tag, ".ex_imm"}, ex_imm, 32'd0);
    chk({tag, ".ex_pc"}, ex_pc, 32'd0);
    chk({tag, ".ex_rd"}, 32'(ex_rd), 32'd0);
    chk({tag, ".ctl"}, 32'({RegWrite_ex, LoadSel_ex, MemWrite_ex}), 32'd0);
    chk({tag, ".ex_alu_op"}, 32'(ex_alu_op), 32'd0);
    chk({tag, ".fwd_illegal"}, 32'(fwd_illegal), 32'd0);
    chk({tag, ".bubble_count"}, 32'(bubble_count), 32'd0);
  endtask

  // asynchronous reset in mid-cycle while a live instruction is presented
  task automatic do_reset(input string tag, input logic stalled);
    @(negedge clock);
    id_valid = 1'b1; RegWrite_ID = 1'b1; rd_ID = 5'd9; pc_en = ~stalled;
    #2;
    reset_n = 1'b0;
    #1;
    check_zero(tag);
    @(negedge clock);
    @(negedge clock);
    id_valid = 1'b0; pc_en = 1'b1; PCSel = 1'b0; RegWrite_ID = 1'b0;
    reset_n = 1'b1;
  endtask

  initial begin
    int c;
    #3;
    check_zero("por");
    @(negedge clock);
    reset_n = 1'b1;

    // ForwardA sweep, then ForwardB sweep
    step(1, 1, 0, 3'd0, 3'd0, 5'd1, 3'b100, 1, 32'h11, 32'h77, 5'd1, 3'b100, 0, 4'd0);
    step(1, 1, 0, 3'd1, 3'd0, 5'd1, 3'b100, 1, 32'h22, 32'h77, 5'd1, 3'b100, 0, 4'd0);
    step(1, 1, 0, 3'd2, 3'd0, 5'd1, 3'b100, 1, 32'h33, 32'h77, 5'd1, 3'b100, 0, 4'd0);
    step(1, 1, 0, 3'd3, 3'd0, 5'd1, 3'b100, 1, 32'h44, 32'h77, 5'd1, 3'b100, 0, 4'd0);
    step(1, 1, 0, 3'd4, 3'd0, 5'd1, 3'b100, 1, 32'h55, 32'h77, 5'd1, 3'b100, 0, 4'd0);
    step(1, 1, 0, 3'd0, 3'd0, 5'd2, 3'b010, 1, 32'h11, 32'h77, 5'd2, 3'b010, 0, 4'd0);
    step(1, 1, 0, 3'd0, 3'd1, 5'd2, 3'b010, 1, 32'h11, 32'h22, 5'd2, 3'b010, 0, 4'd0);
    step(1, 1, 0, 3'd0, 3'd2, 5'd2, 3'b010, 1, 32'h11, 32'h33, 5'd2, 3'b010, 0, 4'd0);
    step(1, 1, 0, 3'd0, 3'd3, 5'd2, 3'b010, 1, 32'h11, 32'h44, 5'd2, 3'b010, 0, 4'd0);
    step(1, 1, 0, 3'd0, 3'd4, 5'd2, 3'b010, 1, 32'h11, 32'h55, 5'd2, 3'b010, 0, 4'd0);

    // illegal code while stalled or with id_valid=0 must not set the flag
    step(1, 0, 0, 3'd7, 3'd0, 5'd3, 3'b100, 0, 32'h11, 32'h77, 5'd0, 3'b000, 0, 4'd1);
    step(0, 1, 0, 3'd5, 3'd0, 5'd3, 3'b100, 0, 32'h11, 32'h77, 5'd0, 3'b000, 0, 4'd1);
    // live illegal code: rf fallback, sticky flag
    step(1, 1, 0, 3'd6, 3'd0, 5'd3, 3'b100, 1, 32'h11, 32'h77, 5'd3, 3'b100, 1, 4'd1);
    step(1, 1, 0, 3'd0, 3'd0, 5'd3, 3'b100, 1, 32'h11, 32'h77, 5'd3, 3'b100, 1, 4'd1);

    do_reset("rst_mid", 1'b0);

    // two-cycle load stall, then capture
    step(1, 0, 0, 3'd0, 3'd0, 5'd5, 3'b100, 0, 32'h11, 32'h77, 5'd0, 3'b000, 0, 4'd1);
    step(1, 0, 0, 3'd0, 3'd0, 5'd5, 3'b100, 0, 32'h11, 32'h77, 5'd0, 3'b000, 0, 4'd2);
    step(1, 1, 0, 3'd1, 3'd0, 5'd5, 3'b100, 1, 32'h22, 32'h77, 5'd5, 3'b100, 0, 4'd2);
    // flush+stall together is one bubble; flush alone is one bubble
    step(1, 0, 1, 3'd0, 3'd0, 5'd6, 3'b001, 0, 32'h11, 32'h77, 5'd0, 3'b000, 0, 4'd3);
    step(1, 1, 1, 3'd0, 3'd0, 5'd6, 3'b111, 0, 32'h11, 32'h77, 5'd0, 3'b000, 0, 4'd4);
    step(1, 1, 0, 3'd0, 3'd2, 5'd6, 3'b011, 1, 32'h11, 32'h33, 5'd6, 3'b011, 0, 4'd4);

    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) begin
      c = (5 + i > 15) ? 15 : 5 + i;
      step(1, 0, 0, 3'd0, 3'd0, 5'd7, 3'b100, 0, 32'h11, 32'h77, 5'd0, 3'b000, 0, 4'(c));
    end

    do_reset("rst_stall", 1'b1);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID-stage operand-select and ID/EX pipeline register for the RV32 core. Applies the 3-bit ForwardA/ForwardB codes from the forwarding block to choose each source operand among register-file, EX, MEM, load-return and WB data, then registers the operands and ID control into the EX stage. It inserts bubbles on load-hazard stalls (pc_en low) and on control-flow flushes (PCSel high), and keeps a saturating bubble counter for debug.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, bubble-counter width

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- pc_en  in  1  0 = load-hazard stall, insert bubble
- PCSel  in  1  1 = taken branch/jump, flush ID
- rs1_data, rs2_data  in  XLEN  register-file read data
- imm_ID, pc_ID  in  XLEN  immediate and PC of ID instruction
- rd_ID  in  5  destination register
- RegWrite_ID, LoadSel_ID, MemWrite_ID  in  1  ID control bits
- alu_op_ID  in  4  ALU operation
- ForwardA, ForwardB  in  3  forward select codes
- fwd_ex_data  in  XLEN  code 001 source
- fwd_mem_data  in  XLEN  code 010 source
- fwd_load_data  in  XLEN  code 011 source
- fwd_wb_data  in  XLEN  code 100 source
- ex_valid  out  1  EX holds a real instruction
- ex_op_a, ex_op_b  out  XLEN  forwarded rs1/rs2 operands
- ex_imm, ex_pc  out  XLEN  registered immediate and PC
- ex_rd  out  5  registered destination
- RegWrite_ex, LoadSel_ex, MemWrite_ex  out  1  registered control bits
- ex_alu_op  out  4  registered ALU op
- fwd_illegal  out  1  sticky flag: an undefined forward code was seen
- bubble_count  out  CNT_W  saturating count of inserted bubbles

## Operation
- Operand mux, per operand, combinational: 000 selects regfile data; 001 ex; 010 mem; 011 load; 100 wb. Codes 101–111 select regfile data and set fwd_illegal. The flag is set only when id_valid=1 and the cycle is not stalled or flushed.
- Register-update priority, highest first:
  - flush (PCSel=1): load a bubble.
  - stall (pc_en=0): load a bubble.
  - normal: capture the ID bundle; ex_valid = id_valid.
- A bubble forces ex_valid, RegWrite_ex, LoadSel_ex and MemWrite_ex to 0 and ex_rd to 0. Data fields may load don't-care values; they must load the current mux output so that the outputs remain deterministic.
- A flush and a stall in the same cycle produce one bubble and one counter increment.
- If id_valid=0 in a normal cycle, the block loads a bubble-equivalent (all control zero) with no counter increment.
- bubble_count increments on each stall or flush cycle and saturates at all-ones. It clears only on reset.
- fwd_illegal clears only on reset.

## Timing
- Reset (asynchronous assert, synchronous-release expected upstream): every output is 0, including ex_op_a/b, ex_imm, ex_pc, ex_alu_op, fwd_illegal and bubble_count.
- Latency: 1 cycle. ID inputs sampled at posedge k appear on EX outputs after posedge k.
- Forwarding sources must be stable before posedge. They are combinational from the same-cycle EX/MEM/WB stages, with no extra pipelining.
- pc_en comes from the negedge-clocked load-hazard FSM. It is sampled at posedge and is stable by then.
- A stall lasts as many posedges as pc_en is low, with one bubble per posedge. ID is held upstream, so the instruction is captured on the first posedge with pc_en=1 and freshly-forwarded operands.
- If reset asserts mid-stall, outputs clear immediately and the counter returns to 0.

## Structure
- Shared package (core_pkg): the forward-code constants FWD_RF=3'b000, FWD_EX=3'b001, FWD_MEM=3'b010, FWD_LOAD=3'b011, FWD_WB=3'b100; the XLEN default; and the alu_op encoding width.
- One sub-module, operand_fwd_mux: a 5:1 XLEN mux plus an illegal-code output, instantiated twice (A and B).
- The pipeline register and counter live in the top module.

## Test plan
- Reset: drive reset_n=0 mid-operation with RegWrite_ID=1 → all outputs 0 asynchronously, and bubble_count=0.
- Forward sweep: rs1_data=0x11, ex=0x22, mem=0x33, load=0x44, wb=0x55. Step ForwardA through 000–100 over 5 cycles → ex_op_a goes 0x11, 0x22, 0x33, 0x44, 0x55 one cycle later each. Repeat the sweep on ForwardB/ex_op_b.
- Illegal code: ForwardA=3'b110, id_valid=1 → ex_op_a=rs1_data and fwd_illegal=1, staying 1 after the code returns to 000.
- Load stall: pc_en=0 for 2 cycles with RegWrite_ID=1, rd_ID=5 → two cycles with ex_valid=0, RegWrite_ex=0, ex_rd=0; bubble_count=2. On the next posedge the instruction is captured with ex_rd=5.
- Flush plus stall together: PCSel=1 and pc_en=0 for one cycle → one bubble, bubble_count +1. MemWrite_ex=0 even though MemWrite_ID=1.
- Saturation: CNT_W=4 with 20 consecutive stall cycles → bubble_count holds 0xF.
